// File: rtl/jkff_bank_sched.sv
`default_nettype none
// ============================================================================
// Module   : jkff_bank_sched
// Purpose  : Round-robin scheduler that grants one of four requesters access
//            to a bank of WIDTH JK flip-flops. The winner's op code and mask
//            are turned into J/K drive vectors for one APPLY cycle. An ACK
//            cycle then follows with a single-cycle done pulse.
// Ports    : clk            - clock; all state changes on the rising edge
//            clrn           - asynchronous active-low reset
//            lock [3:0]     - per-requester lock; only present when the
//                             JKFF_BANK_SCHED_LOCK_EN macro is defined
//            req  [3:0]     - per-requester level request
//            op   [7:0]     - per-requester op, [2i+1:2i]:
//                             00 hold, 01 clear, 10 set, 11 toggle
//            mask [4*W-1:0] - per-requester bit mask, slice i = [W*i +: W]
//            gnt  [3:0]     - registered one-hot grant
//            busy           - FSM not idle
//            done           - one-cycle completion pulse
//            j, k [W-1:0]   - registered J/K drive applied to the bank
//            q    [W-1:0]   - bank state
// Config   : JKFF_BANK_SCHED_LOCK_EN - adds lock input. A locked, still-
//            requesting winner is re-granted directly from ACK.
// Revision : 1.0 - initial release
// ============================================================================
module jkff_bank_sched #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clrn,
`ifdef JKFF_BANK_SCHED_LOCK_EN
  input  logic [3:0]           lock,
`endif
  input  logic [3:0]           req,
  input  logic [7:0]           op,
  input  logic [4*WIDTH-1:0]   mask,
  output logic [3:0]           gnt,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     j,
  output logic [WIDTH-1:0]     k,
  output logic [WIDTH-1:0]     q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       ptr;       // round-robin search start
  logic [1:0]       win;       // requester currently in flight

  logic             found;
  logic [1:0]       pick;
  logic [1:0]       cand;
  logic [1:0]       src;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;
  logic [WIDTH-1:0] j_next;
  logic [WIDTH-1:0] k_next;
  logic             relatch;

  // Round-robin search: first requesting index at ptr, ptr+1, ... (mod 4).
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    cand  = ptr;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // In IDLE the fresh winner is decoded. In ACK a lock re-latch decodes
  // the requester already in flight.
  assign src = (state == ACK) ? win : pick;

  always_comb begin
    sel_op   = 2'b00;
    sel_mask = '0;
    for (int i = 0; i < 4; i++) begin
      if (src == 2'(i)) begin
        sel_op   = op[2*i +: 2];
        sel_mask = mask[WIDTH*i +: WIDTH];
      end
    end
  end

  // Op bit 1 drives J and op bit 0 drives K on every masked bit, so
  // hold/clear/set/toggle map straight onto 00/01/10/11.
  assign j_next = sel_op[1] ? sel_mask : '0;
  assign k_next = sel_op[0] ? sel_mask : '0;

`ifdef JKFF_BANK_SCHED_LOCK_EN
  assign relatch = lock[win] & req[win];
`else
  assign relatch = 1'b0;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      ptr   <= 2'd0;
      win   <= 2'd0;
      gnt   <= 4'b0000;
      done  <= 1'b0;
      j     <= '0;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (found) begin
            win   <= pick;
            gnt   <= 4'b0001 << pick;
            j     <= j_next;
            k     <= k_next;
            state <= APPLY;
          end else begin
            gnt <= 4'b0000;
          end
        end
        APPLY: begin
          // The bank consumes j/k at this edge; drive returns to zero.
          j     <= '0;
          k     <= '0;
          done  <= 1'b1;
          state <= ACK;
        end
        ACK: begin
          done <= 1'b0;
          if (relatch) begin
            j     <= j_next;
            k     <= k_next;
            state <= APPLY;
          end else begin
            gnt   <= 4'b0000;
            ptr   <= win + 2'd1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

  // JK bank: q+ = J&~q | ~K&q. When j and k are zero, every bit holds.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q <= '0;
    end else begin
      q <= (j & ~q) | (~k & q);
    end
  end

endmodule
`default_nettype wire
